hw_checksum_scheduler: RTL and testbench
========================================

HW_CHECKSUM_SCHEDULER -- requirements
Module: hw_checksum_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, WAIT_DONE cycle limit before abort (only with HW_CHECKSUM_TIMEOUT_EN).
REQ-002 pe_clk  input  1  single clock; all logic SHALL run on its rising edge.
REQ-003 pe_rstn  input  1  asynchronous active-low reset.
REQ-004 reqN_valid  input  1  (N=0,1; 0=IP header, 1=ICMP header) byte available from requester N.
REQ-005 reqN_data  input  8  byte from requester N.
REQ-006 reqN_last  input  1  current byte is the final byte of the header.
REQ-007 reqN_ready  output  1  byte accepted when reqN_valid && reqN_ready.
REQ-008 resN_valid  output  1  one-cycle pulse: checksum for requester N is ready.
REQ-009 res_checksum  output  16  checksum result; held until the next RESP.
REQ-010 res_err  output  1  one-cycle timeout pulse (only with HW_CHECKSUM_TIMEOUT_EN; tied 0 otherwise).
REQ-011 eng_clr, eng_start, eng_data_valid, eng_finish  output  1 each  checksum engine controls.
REQ-012 eng_data  output  8  byte to the engine.
REQ-013 eng_checksum  input  16  engine result; eng_done  input  1  engine completion level.

Function
REQ-014 FSM states: IDLE, START, STREAM, FINISH, WAIT_DONE, RESP, CLEAR.
REQ-015 IDLE: if any reqN_valid, grant one requester and go to START; otherwise remain in IDLE.
REQ-016 Arbitration SHALL be round-robin: if both requesters are valid, grant the one not granted last; if one is valid, grant it; the grant register updates on leaving IDLE.
REQ-017 START: eng_start=1 for exactly one cycle, then STREAM; no byte is accepted in START.
REQ-018 STREAM: only the granted requester's ready=reqN_valid; eng_data_valid=reqG_valid, eng_data=reqG_data combinationally (zero added latency).
REQ-019 STREAM: on acceptance with reqG_last=1, go to FINISH; the ungranted requester's ready SHALL stay 0 throughout.
REQ-020 FINISH: eng_finish=1 for exactly one cycle, eng_data_valid=0, then WAIT_DONE.
REQ-021 WAIT_DONE: on eng_done=1, latch eng_checksum into res_checksum and go to RESP.
REQ-022 RESP: resG_valid=1 for exactly one cycle, then CLEAR.
REQ-023 CLEAR: eng_clr=1 for exactly one cycle, then IDLE; the next grant is therefore never earlier than 1 cycle after CLEAR.
REQ-024 A header with an odd byte count SHALL be passed unchanged; the engine performs zero-padding.
REQ-025 A one-byte header (valid && last in the first STREAM cycle) SHALL follow the normal START->STREAM->FINISH path.
REQ-026 Requests arriving outside IDLE are held off (ready=0) and never dropped.
REQ-027 All engine control outputs SHALL be 0 in every state except their defined assertion state.

Reset
REQ-028 On pe_rstn=0: state=IDLE; all outputs 0; res_checksum=16'h0; grant register=1, so requester 0 wins the first contention.
REQ-029 A reset mid-operation SHALL abort immediately with no resN_valid pulse; the engine is expected to share pe_rstn.

Configuration
REQ-030 With macro HW_CHECKSUM_TIMEOUT_EN defined: a counter starts at 0 on entry to WAIT_DONE.
REQ-031 With the macro defined: if eng_done is still 0 after TIMEOUT_CYCLES cycles, res_err=1 for one cycle, no resN_valid, res_checksum unchanged, then CLEAR.
REQ-032 With the macro undefined: no counter is built, res_err=0, and WAIT_DONE waits indefinitely.

Verification
REQ-033 req0 bytes 00 01 F2 03 (last on 03) -> eng_start one cycle before the first byte, eng_finish one cycle after 03, res0_valid pulse with res_checksum=16'h0DFB, then an eng_clr pulse.
REQ-034 req1 odd bytes 12 34 56 -> res1_valid pulse with res_checksum=16'h97CB; req0_ready stays 0 throughout.
REQ-035 req0 and req1 valid in the same IDLE cycle after reset -> req0 is served first, req1 second; repeat the contention -> req0 is served after req1 (alternation).
REQ-036 req0 single byte FF with last=1 -> full sequence completes, res_checksum=16'h00FF.
REQ-037 pe_rstn asserted during STREAM of req0 -> all outputs 0 next cycle, no res0_valid; a new request after reset completes normally.
REQ-038 With HW_CHECKSUM_TIMEOUT_EN and eng_done stubbed to 0 -> res_err pulse 64 cycles after WAIT_DONE entry, then eng_clr, then IDLE.

Source files
------------

// File: rtl/hw_checksum_scheduler.sv
// Two-requester round-robin scheduler feeding header bytes to a shared checksum engine.
// Optional WAIT_DONE timeout: define HW_CHECKSUM_TIMEOUT_EN.
module hw_checksum_scheduler #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        pe_clk,
    input  logic        pe_rstn,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic        res0_valid,
    output logic        res1_valid,
    output logic [15:0] res_checksum,
    output logic        res_err,
    output logic        eng_clr,
    output logic        eng_start,
    output logic        eng_data_valid,
    output logic        eng_finish,
    output logic [7:0]  eng_data,
    input  logic [15:0] eng_checksum,
    input  logic        eng_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        FINISH,
        WAIT_DONE,
        RESP,
        CLEAR
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       grant;
    logic       grant_nxt;
    logic       sel_valid;
    logic       sel_last;
    logic [7:0] sel_data;
    logic       timeout;

    assign sel_valid = grant ? req1_valid : req0_valid;
    assign sel_last  = grant ? req1_last  : req0_last;
    assign sel_data  = grant ? req1_data  : req0_data;

`ifdef HW_CHECKSUM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] wait_cnt;

    // Counts cycles spent in WAIT_DONE; we leave the state before it can wrap.
    always_ff @(posedge pe_clk or negedge pe_rstn) begin
        if (!pe_rstn) begin
            wait_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout = (state == WAIT_DONE) && !eng_done && (wait_cnt == TO_LIMIT);
`else
    assign timeout = 1'b0;
`endif

    assign res_err = timeout;

    always_ff @(posedge pe_clk or negedge pe_rstn) begin
        if (!pe_rstn) begin
            state        <= IDLE;
            grant        <= 1'b1;
            res_checksum <= 16'h0000;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (state == WAIT_DONE && eng_done) begin
                res_checksum <= eng_checksum;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        res0_valid     = 1'b0;
        res1_valid     = 1'b0;
        eng_clr        = 1'b0;
        eng_start      = 1'b0;
        eng_data_valid = 1'b0;
        eng_finish     = 1'b0;
        eng_data       = 8'h00;
        case (state)
            IDLE: begin
                // Under contention the requester not granted last wins.
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) begin
                        grant_nxt = ~grant;
                    end else begin
                        grant_nxt = req1_valid;
                    end
                    state_nxt = START;
                end
            end
            START: begin
                eng_start = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                req0_ready     = !grant && req0_valid;
                req1_ready     = grant && req1_valid;
                eng_data_valid = sel_valid;
                eng_data       = sel_data;
                if (sel_valid && sel_last) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                eng_finish = 1'b1;
                state_nxt  = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (eng_done) begin
                    state_nxt = RESP;
                end else if (timeout) begin
                    state_nxt = CLEAR;
                end
            end
            RESP: begin
                res0_valid = !grant;
                res1_valid = grant;
                state_nxt  = CLEAR;
            end
            CLEAR: begin
                eng_clr   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hw_checksum_scheduler.sv
// Directed self-checking bench for hw_checksum_scheduler with a behavioural checksum engine.
module tb_hw_checksum_scheduler;

    typedef logic [7:0] byte_q_t[$];

    logic        pe_clk = 1'b0;
    logic        pe_rstn = 1'b0;
    logic        req0_valid = 1'b0;
    logic [7:0]  req0_data = 8'h00;
    logic        req0_last = 1'b0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [7:0]  req1_data = 8'h00;
    logic        req1_last = 1'b0;
    logic        req1_ready;
    logic        res0_valid;
    logic        res1_valid;
    logic [15:0] res_checksum;
    logic        res_err;
    logic        eng_clr;
    logic        eng_start;
    logic        eng_data_valid;
    logic        eng_finish;
    logic [7:0]  eng_data;
    logic [15:0] eng_checksum;
    logic        eng_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit stub_done = 1'b0;

    int start_cnt, finish_cnt, res0_cnt, res1_cnt, clr_cnt, err_cnt, err_total;
    int r0_seen, r1_seen;
    int start_cyc, finish_cyc, res0_cyc, res1_cyc, clr_cyc, err_cyc;
    logic [15:0] res0_sum, res1_sum;
    int          res_id_q[$];
    logic [15:0] res_sum_q[$];

    hw_checksum_scheduler #(.TIMEOUT_CYCLES(64)) dut (
        .pe_clk(pe_clk), .pe_rstn(pe_rstn),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .res0_valid(res0_valid), .res1_valid(res1_valid), .res_checksum(res_checksum), .res_err(res_err),
        .eng_clr(eng_clr), .eng_start(eng_start), .eng_data_valid(eng_data_valid),
        .eng_finish(eng_finish), .eng_data(eng_data),
        .eng_checksum(eng_checksum), .eng_done(eng_done)
    );

    always #5 pe_clk = ~pe_clk;

    always @(posedge pe_clk) cyc <= cyc + 1;

    // Engine model: 16-bit one's complement sum, high byte first, odd tail zero-padded.
    logic [15:0] acc;
    logic        odd;
    logic        busy;
    int          dly;

    function automatic logic [15:0] fold(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    always @(posedge pe_clk or negedge pe_rstn) begin
        if (!pe_rstn) begin
            acc <= 16'h0; odd <= 1'b0; busy <= 1'b0; dly <= 0;
            eng_done <= 1'b0; eng_checksum <= 16'h0;
        end else if (eng_clr || eng_start) begin
            acc <= 16'h0; odd <= 1'b0; busy <= 1'b0; eng_done <= 1'b0;
        end else begin
            if (eng_data_valid) begin
                acc <= fold(acc, odd ? {8'h00, eng_data} : {eng_data, 8'h00});
                odd <= ~odd;
            end
            if (eng_finish) begin
                busy <= 1'b1; dly <= 2;
            end else if (busy) begin
                if (dly == 0) begin
                    busy <= 1'b0;
                    if (!stub_done) begin
                        eng_done <= 1'b1; eng_checksum <= ~acc;
                    end
                end else begin
                    dly <= dly - 1;
                end
            end
        end
    end

    always @(negedge pe_clk) begin
        if (eng_start)  begin start_cnt++;  start_cyc = cyc;  end
        if (eng_finish) begin finish_cnt++; finish_cyc = cyc; end
        if (eng_clr)    begin clr_cnt++;    clr_cyc = cyc;    end
        if (res_err)    begin err_cnt++; err_total++; err_cyc = cyc; end
        if (req0_ready) r0_seen++;
        if (req1_ready) r1_seen++;
        if (res0_valid) begin
            res0_cnt++; res0_cyc = cyc; res0_sum = res_checksum;
            res_id_q.push_back(0); res_sum_q.push_back(res_checksum);
        end
        if (res1_valid) begin
            res1_cnt++; res1_cyc = cyc; res1_sum = res_checksum;
            res_id_q.push_back(1); res_sum_q.push_back(res_checksum);
        end
    end

    task automatic tick();
        @(posedge pe_clk);
        #1;
    endtask

    task automatic clear_mon();
        start_cnt = 0; finish_cnt = 0; res0_cnt = 0; res1_cnt = 0; clr_cnt = 0; err_cnt = 0;
        r0_seen = 0; r1_seen = 0;
        start_cyc = -1; finish_cyc = -1; res0_cyc = -1; res1_cyc = -1; clr_cyc = -1; err_cyc = -1;
        res_id_q.delete(); res_sum_q.delete();
    endtask

    // Presents one header on requester n; returns the cycles of first and last acceptance.
    task automatic send(input int n, input byte_q_t b, output int fa, output int la, output bit ok);
        int idx = 0;
        int guard = 0;
        ok = 1'b1; fa = -1; la = -1;
        while (idx < b.size()) begin
            if (n == 0) begin
                req0_valid = 1'b1; req0_data = b[idx]; req0_last = (idx == b.size() - 1);
            end else begin
                req1_valid = 1'b1; req1_data = b[idx]; req1_last = (idx == b.size() - 1);
            end
            @(negedge pe_clk);
            if ((n == 0) ? req0_ready : req1_ready) begin
                if (idx == 0) fa = cyc;
                la = cyc;
                idx++;
            end
            tick();
            guard++;
            if (guard > 300) begin
                ok = 1'b0;
                break;
            end
        end
        if (n == 0) begin
            req0_valid = 1'b0; req0_last = 1'b0;
        end else begin
            req1_valid = 1'b0; req1_last = 1'b0;
        end
    endtask

    task automatic wait_clr(input int target, input int limit, output bit ok);
        int n = 0;
        while (clr_cnt < target && n < limit) begin
            tick();
            n++;
        end
        ok = (clr_cnt >= target);
    endtask

    task automatic test_reset();
        pe_rstn = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) tick();
        total++;
        if ({req0_ready, req1_ready, res0_valid, res1_valid, res_err,
             eng_clr, eng_start, eng_data_valid, eng_finish} !== 9'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b want 0", {req0_ready, req1_ready, res0_valid,
                     res1_valid, res_err, eng_clr, eng_start, eng_data_valid, eng_finish});
        end
        total++;
        if (eng_data !== 8'h00) begin
            bad++; $display("[TB] FAIL reset_eng_data: got %h want 00", eng_data);
        end
        total++;
        if (res_checksum !== 16'h0000) begin
            bad++; $display("[TB] FAIL reset_checksum: got %h want 0000", res_checksum);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        pe_rstn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_req0_basic();
        byte_q_t h;
        int fa, la, c0;
        bit ok, okw;
        h = '{8'h00, 8'h01, 8'hF2, 8'h03};
        clear_mon();
        c0 = cyc;
        send(0, h, fa, la, ok);
        wait_clr(1, 100, okw);
        total++;
        if (!(ok && okw)) begin
            bad++; $display("[TB] FAIL req0_complete: got send=%0d clr=%0d want 1 1", ok, okw);
        end
        total++;
        if (fa !== c0 + 2) begin
            bad++; $display("[TB] FAIL req0_first_accept: got cycle %0d want %0d", fa, c0 + 2);
        end
        total++;
        if (start_cnt !== 1 || start_cyc !== fa - 1) begin
            bad++; $display("[TB] FAIL req0_start: got cnt=%0d cyc=%0d want 1 %0d", start_cnt, start_cyc, fa - 1);
        end
        total++;
        if (finish_cnt !== 1 || finish_cyc !== la + 1) begin
            bad++; $display("[TB] FAIL req0_finish: got cnt=%0d cyc=%0d want 1 %0d", finish_cnt, finish_cyc, la + 1);
        end
        total++;
        if (res0_cnt !== 1 || res1_cnt !== 0 || res0_sum !== 16'h0DFB) begin
            bad++; $display("[TB] FAIL req0_result: got r0=%0d r1=%0d sum=%h want 1 0 0DFB", res0_cnt, res1_cnt, res0_sum);
        end
        total++;
        if (clr_cyc !== res0_cyc + 1) begin
            bad++; $display("[TB] FAIL req0_clr: got cycle %0d want %0d", clr_cyc, res0_cyc + 1);
        end
        total++;
        if (r1_seen !== 0) begin
            bad++; $display("[TB] FAIL req0_other_ready: got %0d want 0", r1_seen);
        end
        repeat (3) tick();
        total++;
        if (res_checksum !== 16'h0DFB) begin
            bad++; $display("[TB] FAIL req0_hold: got %h want 0DFB", res_checksum);
        end
    endtask

    task automatic test_odd_req1();
        byte_q_t h;
        int fa, la;
        bit ok, okw;
        h = '{8'h12, 8'h34, 8'h56};
        clear_mon();
        send(1, h, fa, la, ok);
        wait_clr(1, 100, okw);
        total++;
        if (!(ok && okw) || res1_cnt !== 1 || res0_cnt !== 0 || res1_sum !== 16'h97CB) begin
            bad++; $display("[TB] FAIL req1_odd: got ok=%0d r1=%0d r0=%0d sum=%h want 1 1 0 97CB",
                            ok && okw, res1_cnt, res0_cnt, res1_sum);
        end
        total++;
        if (r0_seen !== 0) begin
            bad++; $display("[TB] FAIL req1_other_ready: got %0d want 0", r0_seen);
        end
        total++;
        if (finish_cyc !== la + 1 || start_cyc !== fa - 1) begin
            bad++; $display("[TB] FAIL req1_framing: got start=%0d finish=%0d want %0d %0d",
                            start_cyc, finish_cyc, fa - 1, la + 1);
        end
    endtask

    task automatic test_single_byte();
        byte_q_t h;
        int fa, la;
        bit ok, okw;
        h = '{8'hFF};
        clear_mon();
        send(0, h, fa, la, ok);
        wait_clr(1, 100, okw);
        total++;
        if (!(ok && okw) || res0_cnt !== 1 || res0_sum !== 16'h00FF) begin
            bad++; $display("[TB] FAIL single_byte: got ok=%0d r0=%0d sum=%h want 1 1 00FF", ok && okw, res0_cnt, res0_sum);
        end
        total++;
        if (start_cyc !== fa - 1 || finish_cyc !== fa + 1 || start_cnt !== 1 || finish_cnt !== 1) begin
            bad++; $display("[TB] FAIL single_framing: got start=%0d finish=%0d want %0d %0d",
                            start_cyc, finish_cyc, fa - 1, fa + 1);
        end
    endtask

    task automatic test_back_to_back();
        byte_q_t ha, hb, hc;
        int fa0, la0, fa1, la1, fa2, la2;
        bit ok0, ok1, ok2, okw;
        logic [15:0] want_sum[3];
        int want_id[3];
        ha = '{8'h0A, 8'h0B};
        hb = '{8'h80, 8'h00};
        hc = '{8'h01, 8'h02, 8'h03};
        want_id = '{0, 1, 0};
        want_sum = '{16'hF5F4, 16'hFBFD, 16'h7FFF};
        // Fresh reset so the first contention goes to requester 0.
        pe_rstn = 1'b0;
        tick();
        pe_rstn = 1'b1;
        tick();
        clear_mon();
        fork
            begin
                send(0, ha, fa0, la0, ok0);
                send(0, hb, fa2, la2, ok2);
            end
            send(1, hc, fa1, la1, ok1);
        join
        wait_clr(3, 150, okw);
        total++;
        if (!(ok0 && ok1 && ok2 && okw) || res_id_q.size() !== 3) begin
            bad++; $display("[TB] FAIL b2b_count: got ok=%0d results=%0d want 1 3",
                            ok0 && ok1 && ok2 && okw, res_id_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (res_id_q[i] !== want_id[i] || res_sum_q[i] !== want_sum[i]) begin
                    bad++; $display("[TB] FAIL b2b_order[%0d]: got req%0d sum=%h want req%0d sum=%h",
                                    i, res_id_q[i], res_sum_q[i], want_id[i], want_sum[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        byte_q_t h;
        int fa, la, n;
        bit ok, okw;
        clear_mon();
        req0_valid = 1'b1; req0_data = 8'h11; req0_last = 1'b0;
        n = 0;
        do begin
            @(negedge pe_clk);
            n++;
        end while (!req0_ready && n < 10);
        tick();
        total++;
        if (n >= 10) begin
            bad++; $display("[TB] FAIL mid_reach_stream: got %0d cycles want <10", n);
        end
        pe_rstn = 1'b0;
        #1;
        total++;
        if ({req0_ready, req1_ready, res0_valid, res1_valid, res_err, eng_clr, eng_start,
             eng_data_valid, eng_finish} !== 9'b0 || eng_data !== 8'h00 || res_checksum !== 16'h0) begin
            bad++; $display("[TB] FAIL mid_reset_outputs: got ctrl=%b data=%h sum=%h want 0 00 0000",
                            {req0_ready, req1_ready, res0_valid, res1_valid, res_err, eng_clr,
                             eng_start, eng_data_valid, eng_finish}, eng_data, res_checksum);
        end
        repeat (2) tick();
        req0_valid = 1'b0;
        pe_rstn = 1'b1;
        repeat (5) tick();
        total++;
        if (res0_cnt !== 0 || res1_cnt !== 0) begin
            bad++; $display("[TB] FAIL mid_no_resp: got r0=%0d r1=%0d want 0 0", res0_cnt, res1_cnt);
        end
        clear_mon();
        h = '{8'h00, 8'h01, 8'hF2, 8'h03};
        send(0, h, fa, la, ok);
        wait_clr(1, 100, okw);
        total++;
        if (!(ok && okw) || res0_cnt !== 1 || res0_sum !== 16'h0DFB) begin
            bad++; $display("[TB] FAIL mid_recover: got ok=%0d r0=%0d sum=%h want 1 1 0DFB", ok && okw, res0_cnt, res0_sum);
        end
    endtask

`ifdef HW_CHECKSUM_TIMEOUT_EN
    task automatic test_timeout();
        byte_q_t h;
        int fa, la;
        bit ok, okw;
        logic [15:0] pre;
        h = '{8'h42};
        pre = res_checksum;
        stub_done = 1'b1;
        clear_mon();
        send(0, h, fa, la, ok);
        wait_clr(1, 200, okw);
        total++;
        if (!(ok && okw) || err_cnt !== 1 || err_cyc !== finish_cyc + 65) begin
            bad++; $display("[TB] FAIL timeout_err: got ok=%0d cnt=%0d cyc=%0d want 1 1 %0d",
                            ok && okw, err_cnt, err_cyc, finish_cyc + 65);
        end
        total++;
        if (clr_cyc !== err_cyc + 1 || res0_cnt !== 0 || res_checksum !== pre) begin
            bad++; $display("[TB] FAIL timeout_after: got clr=%0d r0=%0d sum=%h want %0d 0 %h",
                            clr_cyc, res0_cnt, res_checksum, err_cyc + 1, pre);
        end
        stub_done = 1'b0;
        repeat (2) tick();
    endtask
`else
    task automatic test_timeout();
        total++;
        if (err_total !== 0) begin
            bad++; $display("[TB] FAIL no_timeout_err: got %0d pulses want 0", err_total);
        end
    endtask
`endif

    initial begin
        err_total = 0;
        clear_mon();
        test_reset();
        test_req0_basic();
        test_odd_req1();
        test_single_byte();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
